// File: rtl/ss_display_capture.sv
// Seven-segment receive monitor: samples the multiplexed digit enables and segments,
// accepts stable patterns, decodes them to BCD and publishes an HH:MM frame with status flags.
module ss_display_capture #(
    parameter int STABLE_CYCLES = 1000,
    parameter int FRAME_TIMEOUT = 2000000
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] SegmentDrivers,
    input  logic [7:0] SevenSegment,
    output logic [3:0] hours2_o,
    output logic [3:0] hours1_o,
    output logic [3:0] mins2_o,
    output logic [3:0] mins1_o,
    output logic [3:0] dp_o,
    output logic       frame_valid,
    output logic       time_err,
    output logic       seg_err,
    output logic       enable_err,
    output logic       stale
);

    localparam int RW = 16;
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       en_q, prev_en_q;
    logic [7:0]       seg_q, prev_seg_q;
    logic [RW-1:0]    run_q, run_d;
    logic [3:0]       mask_q, mask_d, mask_acc;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic [3:0]       dp_q, dp_d;
    logic             time_err_q, time_err_d;
    logic             frame_valid_q, seg_err_q, enable_err_q;
    logic [TW-1:0]    to_q, to_d;
    logic             stale_q, stale_d;

    logic             pair_change;
    logic             accept, accept_digit, seg_err_d, enable_err_d, publish;
    logic             en_onehot;
    logic [1:0]       en_idx;
    logic             dec_legal;
    logic [3:0]       dec_val;

    // Pattern is active-high gfedcba; returns {legal, bcd}. All-dark is a legal blank.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'h3F:   decode_seg = {1'b1, 4'd0};
            7'h06:   decode_seg = {1'b1, 4'd1};
            7'h5B:   decode_seg = {1'b1, 4'd2};
            7'h4F:   decode_seg = {1'b1, 4'd3};
            7'h66:   decode_seg = {1'b1, 4'd4};
            7'h6D:   decode_seg = {1'b1, 4'd5};
            7'h7D:   decode_seg = {1'b1, 4'd6};
            7'h07:   decode_seg = {1'b1, 4'd7};
            7'h7F:   decode_seg = {1'b1, 4'd8};
            7'h6F:   decode_seg = {1'b1, 4'd9};
            7'h00:   decode_seg = {1'b1, 4'hF};
            default: decode_seg = {1'b0, 4'hF};
        endcase
    endfunction

    // Digit order inside the packed frame: [3]=hours2, [2]=hours1, [1]=mins2, [0]=mins1.
    function automatic logic frame_time_err(input logic [3:0][3:0] d);
        logic blank;
        logic hours_bad;
        blank = (d[3] == 4'hF) || (d[2] == 4'hF) || (d[1] == 4'hF) || (d[0] == 4'hF);
        hours_bad = (d[3] > 4'd2) || ((d[3] == 4'd2) && (d[2] > 4'd3));
        frame_time_err = blank || hours_bad || (d[1] > 4'd5);
    endfunction

    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pair_change = {en_q, seg_q} != {prev_en_q, prev_seg_q};

    always_comb begin
        state_d = state_q;
        if (pair_change) begin
            state_d = (en_q == 4'hF) ? S_IDLE : S_SETTLE;
        end else begin
            case (state_q)
                S_SETTLE: if (run_q == RUN_MAX) state_d = S_HELD;
                default:  state_d = state_q;
            endcase
        end
    end

    // Exactly one acceptance per stable window: the SETTLE cycle in which the run completes.
    always_comb begin
        accept       = (state_q == S_SETTLE) && !pair_change && (run_q == RUN_MAX);
        accept_digit = accept && en_onehot && dec_legal;
        seg_err_d    = accept && en_onehot && !dec_legal;
        enable_err_d = accept && !en_onehot && (en_q != 4'hF);
    end

    always_comb begin
        en_onehot = 1'b1;
        en_idx    = 2'd0;
        case (en_q)
            4'b1110: en_idx = 2'd0;
            4'b1101: en_idx = 2'd1;
            4'b1011: en_idx = 2'd2;
            4'b0111: en_idx = 2'd3;
            default: en_onehot = 1'b0;
        endcase
    end

    assign {dec_legal, dec_val} = decode_seg(~seg_q[6:0]);

    always_comb begin
        if (pair_change) begin
            run_d = RW'(1);
        end else if (run_q == RUN_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + RW'(1);
        end
    end

    // Publish sees the digit accepted this cycle, so the frame completes without an extra wait.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        mask_acc    = mask_q;
        if (accept_digit) begin
            shadow_d[en_idx]    = dec_val;
            shadow_dp_d[en_idx] = ~seg_q[7];
            mask_acc[en_idx]    = 1'b1;
        end
        publish = accept_digit && (mask_acc == 4'hF);
        mask_d  = publish ? 4'h0 : mask_acc;
    end

    always_comb begin
        digits_d   = digits_q;
        dp_d       = dp_q;
        time_err_d = time_err_q;
        if (publish) begin
            digits_d   = shadow_d;
            dp_d       = shadow_dp_d;
            time_err_d = frame_time_err(shadow_d);
        end
    end

    always_comb begin
        if (publish) begin
            to_d = '0;
        end else if (to_q == TO_MAX) begin
            to_d = to_q;
        end else begin
            to_d = to_q + TW'(1);
        end
        stale_d = !publish && (to_d == TO_MAX);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            en_q          <= 4'hF;
            seg_q         <= 8'hFF;
            prev_en_q     <= 4'hF;
            prev_seg_q    <= 8'hFF;
            run_q         <= '0;
            mask_q        <= 4'h0;
            shadow_q      <= '0;
            shadow_dp_q   <= 4'h0;
            digits_q      <= '0;
            dp_q          <= 4'h0;
            time_err_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            enable_err_q  <= 1'b0;
            to_q          <= '0;
            stale_q       <= 1'b0;
        end else begin
            en_q          <= SegmentDrivers;
            seg_q         <= SevenSegment;
            prev_en_q     <= en_q;
            prev_seg_q    <= seg_q;
            run_q         <= run_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            time_err_q    <= time_err_d;
            frame_valid_q <= publish;
            seg_err_q     <= seg_err_d;
            enable_err_q  <= enable_err_d;
            to_q          <= to_d;
            stale_q       <= stale_d;
        end
    end

    // frame_valid is a single-cycle strobe with no back-pressure; digit outputs are
    // valid and stable from that cycle until the next strobe.
    assign hours2_o    = digits_q[3];
    assign hours1_o    = digits_q[2];
    assign mins2_o     = digits_q[1];
    assign mins1_o     = digits_q[0];
    assign dp_o        = dp_q;
    assign frame_valid = frame_valid_q;
    assign time_err    = time_err_q;
    assign seg_err     = seg_err_q;
    assign enable_err  = enable_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_ss_display_capture.sv
// Scoreboard bench for ss_display_capture: a pin-level window model predicts frames and
// error pulses at drive time; a negedge monitor pops and compares whenever the DUT reports.
module tb_ss_display_capture;

    localparam int S  = 4;
    localparam int FT = 200;
    localparam int FW = 21;

    logic       CLK100MHZ = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] SegmentDrivers = 4'hF;
    logic [7:0] SevenSegment = 8'hFF;
    logic [3:0] hours2_o, hours1_o, mins2_o, mins1_o, dp_o;
    logic       frame_valid, time_err, seg_err, enable_err, stale;

    always #5 CLK100MHZ = ~CLK100MHZ;

    ss_display_capture #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
        .CLK100MHZ     (CLK100MHZ),
        .Reset         (Reset),
        .SegmentDrivers(SegmentDrivers),
        .SevenSegment  (SevenSegment),
        .hours2_o      (hours2_o),
        .hours1_o      (hours1_o),
        .mins2_o       (mins2_o),
        .mins1_o       (mins1_o),
        .dp_o          (dp_o),
        .frame_valid   (frame_valid),
        .time_err      (time_err),
        .seg_err       (seg_err),
        .enable_err    (enable_err),
        .stale         (stale)
    );

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] exp_q[$];
    logic [1:0]    err_q[$];

    int         seg_code[10] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66,
                                 32'h6D, 32'h7D, 32'h07, 32'h7F, 32'h6F};
    logic [6:0] bad_pat[5] = '{7'h49, 7'h01, 7'h7E, 7'h40, 7'h55};
    logic [3:0] bad_en[6]  = '{4'b0000, 4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b1001};

    logic [3:0]  sh[4];
    logic [3:0]  sh_dp;
    logic [3:0]  mask_m;
    logic [11:0] last_pair;
    int          run_m;

    int            cyc = 0;
    bit            rst_seen = 1'b1;
    int            last_clear = 0;
    logic [FW-1:0] out_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat(input int d, input bit dp);
        logic [6:0] p;
        if (d < 0) p = 7'h00;
        else p = 7'(seg_code[d]);
        return ~{dp, p};
    endfunction

    function automatic logic [3:0] en_of(input int pos);
        logic [3:0] m;
        m = 4'b0001 << pos;
        return ~m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) sh[i] = 4'h0;
        sh_dp = 4'h0;
        mask_m = 4'h0;
        last_pair = {4'hF, 8'hFF};
        run_m = 1000;
    endtask

    // One accepted stable window: classify it and update the frame under construction.
    task automatic model_accept(input logic [3:0] en, input logic [7:0] seg);
        logic [6:0] p;
        logic [3:0] m;
        int v;
        int idx;
        int hours;
        bit te;
        p = ~seg[6:0];
        v = -1;
        idx = -1;
        if (p == 7'h00) v = 15;
        for (int i = 0; i < 10; i++) if (7'(seg_code[i]) == p) v = i;
        for (int i = 0; i < 4; i++) begin
            m = 4'b0001 << i;
            if (en == ~m) idx = i;
        end
        if (idx < 0) begin
            err_q.push_back(2'd2);
        end else if (v < 0) begin
            err_q.push_back(2'd1);
        end else begin
            sh[idx] = 4'(v);
            sh_dp[idx] = ~seg[7];
            mask_m[idx] = 1'b1;
            if (mask_m == 4'hF) begin
                hours = int'(sh[3]) * 10 + int'(sh[2]);
                te = (sh[0] == 4'hF) || (sh[1] == 4'hF) || (sh[2] == 4'hF) || (sh[3] == 4'hF)
                     || (hours > 23) || (sh[1] > 4'd5);
                exp_q.push_back({sh[3], sh[2], sh[1], sh[0], sh_dp, te});
                mask_m = 4'h0;
            end
        end
    endtask

    // A pin pair held for at least S+1 consecutive clocks forms one accepted window.
    task automatic drive(input logic [3:0] en, input logic [7:0] seg, input int hold);
        int base;
        @(negedge CLK100MHZ);
        SegmentDrivers = en;
        SevenSegment = seg;
        base = ({en, seg} == last_pair) ? run_m : 0;
        if (en != 4'hF && base < S + 1 && base + hold >= S + 1) model_accept(en, seg);
        run_m = base + hold;
        last_pair = {en, seg};
        repeat (hold - 1) @(negedge CLK100MHZ);
    endtask

    task automatic idle(input int n);
        drive(4'hF, 8'hFF, n);
    endtask

    task automatic scan(input int d3, input int d2, input int d1, input int d0,
                        input int hold, input logic [3:0] dps);
        drive(en_of(3), pat(d3, dps[3]), hold);
        drive(en_of(2), pat(d2, dps[2]), hold);
        drive(en_of(1), pat(d1, dps[1]), hold);
        drive(en_of(0), pat(d0, dps[0]), hold);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK100MHZ);
        Reset = 1'b1;
        SegmentDrivers = 4'hF;
        SevenSegment = 8'hFF;
        repeat (n - 1) @(negedge CLK100MHZ);
        Reset = 1'b0;
        model_clear();
    endtask

    always @(posedge CLK100MHZ) begin
        cyc <= cyc + 1;
        rst_seen <= Reset;
    end

    always @(negedge CLK100MHZ) begin
        logic [1:0] got_err;
        logic [1:0] want_err;
        if (rst_seen) begin
            out_m = '0;
            last_clear = cyc;
            check("pulses_in_reset", 32'({frame_valid, seg_err, enable_err}), 32'(0));
        end else begin
            if (frame_valid) begin
                last_clear = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_valid: got publish expected none pending (cycle %0d)", cyc);
                end else begin
                    out_m = exp_q.pop_front();
                end
            end
            got_err = {enable_err, seg_err};
            if (got_err != 2'd0) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL error_pulse: got kind %0d expected none pending (cycle %0d)", got_err, cyc);
                end else begin
                    want_err = err_q.pop_front();
                    checks--;
                    check("error_pulse_kind", 32'(got_err), 32'(want_err));
                end
            end
        end
        check("outputs", 32'({hours2_o, hours1_o, mins2_o, mins1_o, dp_o, time_err}), 32'(out_m));
        check("stale", 32'(stale), 32'((cyc - last_clear) >= FT));
    end

    initial begin
        int kind;
        int hold;
        int pos;
        int d;
        model_clear();
        do_reset(3);

        scan(1, 2, 3, 4, 8, 4'b0000);
        idle(8);
        scan(2, 5, 6, 0, 8, 4'b0000);
        scan(0, 9, 7, 9, 8, 4'b0100);
        idle(8);

        drive(en_of(3), pat(1, 1'b0), 8);
        drive(en_of(2), pat(2, 1'b0), 8);
        drive(en_of(1), pat(3, 1'b0), 8);
        drive(en_of(0), 8'hFF ^ 8'h49, 8);
        idle(8);
        drive(en_of(0), pat(5, 1'b1), 8);

        drive(4'b1100, pat(4, 1'b0), 8);
        drive(en_of(3), pat(2, 1'b0), 8);
        drive(en_of(3), pat(7, 1'b0), 3);
        drive(en_of(3), pat(2, 1'b0), 8);
        drive(en_of(2), pat(0, 1'b1), 8);
        drive(en_of(2), pat(1, 1'b0), 8);
        drive(en_of(1), pat(4, 1'b0), 8);
        drive(en_of(0), pat(-1, 1'b0), 8);

        idle(250);
        scan(2, 3, 5, 9, 8, 4'b1001);

        drive(en_of(3), pat(1, 1'b0), 8);
        drive(en_of(2), pat(8, 1'b0), 8);
        idle(8);
        do_reset(3);
        drive(en_of(1), pat(4, 1'b0), 8);
        drive(en_of(0), pat(2, 1'b0), 8);
        drive(en_of(3), pat(0, 1'b0), 8);
        idle(8);
        drive(en_of(2), pat(6, 1'b0), 8);
        idle(8);

        for (int n = 0; n < 160; n++) begin
            kind = $urandom_range(0, 99);
            hold = $urandom_range(2, 10);
            pos  = $urandom_range(0, 3);
            if (kind < 78) begin
                d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 9));
                drive(en_of(pos), pat(d, 1'($urandom_range(0, 1))), hold);
            end else if (kind < 86) begin
                drive(en_of(pos), ~{1'b1, bad_pat[$urandom_range(0, 4)]}, hold);
            end else if (kind < 94) begin
                drive(bad_en[$urandom_range(0, 5)], pat(int'($urandom_range(0, 9)), 1'b0), hold);
            end else begin
                idle(hold);
            end
        end

        idle(S + 4);
        check("frames_drained", 32'(exp_q.size()), 32'(0));
        check("errors_drained", 32'(err_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
